control_sequencer: RTL and testbench

- Multicycle control FSM for the 16-bit datapath.
- Drives the clock-enable strobes of the datapath enable-registers: IR, PC, ALU-out and register-file write.
- Issues memory requests with a ready/ack handshake and decodes the opcode field read back from the IR register output.
- Sits directly upstream of the datapath register bank; each strobe lands on one register's clkEn.

---
 rtl/control_sequencer.sv | 140 ++++++++++++++
 tb/tb_control_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multicycle control FSM for the 16-bit datapath: sequences fetch/decode/execute,
// drives the register clock-enable strobes and the memory request handshake.
module control_sequencer #(
    parameter int OPW      = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           memAck,
    output logic           memReq,
    output logic           memWe,
    output logic           irEn,
    output logic           pcEn,
    output logic           aluOutEn,
    output logic           regWrEn,
    output logic           halted,
    output logic           fault,
    output logic [2:0]     state
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE, C_JUMP, C_HALT, C_ILL
    } op_class_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [CW-1:0]  wait_cnt, wait_d;
    op_class_t      dec_class, exec_class;
    state_t         next_instr;
    logic           wait_expired;

    function automatic op_class_t op_class(input logic [OPW-1:0] op);
        if (op == '0)                 return C_NOP;
        else if (op <= OPW'(7))       return C_ALU;
        else if (op == OPW'(8))       return C_LOAD;
        else if (op == OPW'(9))       return C_STORE;
        else if (op == OPW'(10))      return C_JUMP;
        else if (op == OPW'(15))      return C_HALT;
        else                          return C_ILL;
    endfunction

    assign dec_class    = op_class(opcode);
    assign exec_class   = op_class(op_q);
    assign next_instr   = run ? S_FETCH : S_IDLE;
    assign wait_expired = (wait_cnt == CW'(WAIT_MAX - 1));
    assign state        = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    // wait_d defaults to zero so the counter is clear on every entry to FETCH/MEM
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        irEn     = 1'b0;
        pcEn     = 1'b0;
        aluOutEn = 1'b0;
        regWrEn  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                memReq = 1'b1;
                irEn   = memAck;
                pcEn   = memAck;
                if (memAck)            state_d = S_DECODE;
                else if (wait_expired) state_d = S_FAULT;
                else                   wait_d  = wait_cnt + CW'(1);
            end
            S_DECODE: begin
                case (dec_class)
                    C_NOP:                          state_d = next_instr;
                    C_ALU, C_LOAD, C_STORE, C_JUMP: state_d = S_EXEC;
                    C_HALT:                         state_d = S_HALT;
                    default:                        state_d = S_FAULT;
                endcase
            end
            S_EXEC: begin
                case (exec_class)
                    C_ALU: begin
                        aluOutEn = 1'b1;
                        state_d  = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        aluOutEn = 1'b1;
                        state_d  = S_MEM;
                    end
                    C_JUMP: begin
                        pcEn    = 1'b1;
                        state_d = next_instr;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                memReq = 1'b1;
                memWe  = (exec_class == C_STORE);
                if (memAck)            state_d = (exec_class == C_LOAD) ? S_WB : next_instr;
                else if (wait_expired) state_d = S_FAULT;
                else                   wait_d  = wait_cnt + CW'(1);
            end
            S_WB: begin
                regWrEn = 1'b1;
                state_d = next_instr;
            end
            S_HALT:  halted = 1'b1;
            default: fault  = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vectors of run/memAck/opcode
// with hand-derived state and strobe expectations.
module tb_control_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic       memAck;
    logic       memReq, memWe, irEn, pcEn, aluOutEn, regWrEn, halted, fault;
    logic [2:0] state;
    logic [10:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // expected bits: {memReq, memWe, irEn, pcEn, aluOutEn, regWrEn, halted, fault}
    typedef struct packed {
        logic       r;
        logic       a;
        logic [3:0] op;
        logic [2:0] st;
        logic [7:0] b;
    } vec_t;

    control_sequencer #(.OPW(4), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .memAck(memAck),
        .memReq(memReq), .memWe(memWe), .irEn(irEn), .pcEn(pcEn),
        .aluOutEn(aluOutEn), .regWrEn(regWrEn), .halted(halted), .fault(fault),
        .state(state)
    );

    assign obs = {state, memReq, memWe, irEn, pcEn, aluOutEn, regWrEn, halted, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_reset;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; run = 1'b0; memAck = 1'b0; opcode = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; run = 1'b1; memAck = 1'b1; opcode = 4'h3;
        @(negedge clk); @(negedge clk);
        #1;
        n_checks++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", obs, 11'h000);
        end
        @(negedge clk);
        reset = 1'b1; run = 1'b0; memAck = 1'b0; opcode = 4'h0;
        #1;
        n_checks++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, 11'h000);
        end
        @(negedge clk);
    endtask

    task automatic test_alu;
        vec_t v [9] = '{
            {1'b1, 1'b1, 4'h3, 3'd0, 8'b0000_0000},
            {1'b1, 1'b1, 4'h3, 3'd1, 8'b1011_0000},
            {1'b1, 1'b1, 4'h3, 3'd2, 8'b0000_0000},
            {1'b1, 1'b1, 4'h3, 3'd3, 8'b0000_1000},
            {1'b1, 1'b1, 4'h3, 3'd5, 8'b0000_0100},
            {1'b1, 1'b1, 4'h0, 3'd1, 8'b1011_0000},
            {1'b0, 1'b1, 4'h0, 3'd2, 8'b0000_0000},
            {1'b0, 1'b1, 4'h0, 3'd0, 8'b0000_0000},
            {1'b0, 1'b1, 4'h0, 3'd0, 8'b0000_0000}
        };
        for (int i = 0; i < 9; i++) begin
            run = v[i].r; memAck = v[i].a; opcode = v[i].op;
            #1;
            n_checks++;
            if (obs !== {v[i].st, v[i].b}) begin
                n_fail++;
                $display("FAIL alu[%0d]: got %h expected %h", i, obs, {v[i].st, v[i].b});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump;
        vec_t v [7] = '{
            {1'b1, 1'b1, 4'hA, 3'd0, 8'b0000_0000},
            {1'b1, 1'b1, 4'hA, 3'd1, 8'b1011_0000},
            {1'b1, 1'b1, 4'hA, 3'd2, 8'b0000_0000},
            {1'b1, 1'b1, 4'hA, 3'd3, 8'b0001_0000},
            {1'b1, 1'b1, 4'h0, 3'd1, 8'b1011_0000},
            {1'b0, 1'b1, 4'h0, 3'd2, 8'b0000_0000},
            {1'b0, 1'b0, 4'h0, 3'd0, 8'b0000_0000}
        };
        for (int i = 0; i < 7; i++) begin
            run = v[i].r; memAck = v[i].a; opcode = v[i].op;
            #1;
            n_checks++;
            if (obs !== {v[i].st, v[i].b}) begin
                n_fail++;
                $display("FAIL jump[%0d]: got %h expected %h", i, obs, {v[i].st, v[i].b});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load;
        vec_t v [11] = '{
            {1'b1, 1'b0, 4'h8, 3'd0, 8'b0000_0000},
            {1'b1, 1'b0, 4'h8, 3'd1, 8'b1000_0000},
            {1'b1, 1'b0, 4'h8, 3'd1, 8'b1000_0000},
            {1'b1, 1'b1, 4'h8, 3'd1, 8'b1011_0000},
            {1'b1, 1'b0, 4'h8, 3'd2, 8'b0000_0000},
            {1'b1, 1'b0, 4'h8, 3'd3, 8'b0000_1000},
            {1'b1, 1'b0, 4'h8, 3'd4, 8'b1000_0000},
            {1'b1, 1'b0, 4'h8, 3'd4, 8'b1000_0000},
            {1'b1, 1'b1, 4'h8, 3'd4, 8'b1000_0000},
            {1'b0, 1'b0, 4'h8, 3'd5, 8'b0000_0100},
            {1'b0, 1'b0, 4'h8, 3'd0, 8'b0000_0000}
        };
        for (int i = 0; i < 11; i++) begin
            run = v[i].r; memAck = v[i].a; opcode = v[i].op;
            #1;
            n_checks++;
            if (obs !== {v[i].st, v[i].b}) begin
                n_fail++;
                $display("FAIL load[%0d]: got %h expected %h", i, obs, {v[i].st, v[i].b});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_run_drop;
        vec_t v [8] = '{
            {1'b1, 1'b0, 4'h9, 3'd0, 8'b0000_0000},
            {1'b1, 1'b1, 4'h9, 3'd1, 8'b1011_0000},
            {1'b1, 1'b0, 4'h9, 3'd2, 8'b0000_0000},
            {1'b1, 1'b0, 4'hF, 3'd3, 8'b0000_1000},
            {1'b0, 1'b0, 4'hF, 3'd4, 8'b1100_0000},
            {1'b0, 1'b1, 4'hF, 3'd4, 8'b1100_0000},
            {1'b0, 1'b1, 4'hF, 3'd0, 8'b0000_0000},
            {1'b0, 1'b0, 4'h0, 3'd0, 8'b0000_0000}
        };
        for (int i = 0; i < 8; i++) begin
            run = v[i].r; memAck = v[i].a; opcode = v[i].op;
            #1;
            n_checks++;
            if (obs !== {v[i].st, v[i].b}) begin
                n_fail++;
                $display("FAIL store[%0d]: got %h expected %h", i, obs, {v[i].st, v[i].b});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        run = 1'b1; memAck = 1'b0; opcode = 4'h0;
        @(negedge clk);
        while (memReq === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (req_cycles != 15) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cycles, 15);
        end
        for (int i = 0; i < 5; i++) begin
            run = i[0]; memAck = ~i[0];
            #1;
            n_checks++;
            if (obs !== {3'd7, 8'b0000_0001}) begin
                n_fail++;
                $display("FAIL timeout_fault[%0d]: got %h expected %h", i, obs, {3'd7, 8'b0000_0001});
            end
            @(negedge clk);
        end
        pulse_reset();
    endtask

    task automatic test_illegal_and_halt;
        vec_t v [11] = '{
            {1'b1, 1'b1, 4'hC, 3'd0, 8'b0000_0000},
            {1'b1, 1'b1, 4'hC, 3'd1, 8'b1011_0000},
            {1'b1, 1'b1, 4'hC, 3'd2, 8'b0000_0000},
            {1'b0, 1'b1, 4'h0, 3'd7, 8'b0000_0001},
            {1'b1, 1'b1, 4'h0, 3'd7, 8'b0000_0001},
            {1'b1, 1'b1, 4'hF, 3'd0, 8'b0000_0000},
            {1'b1, 1'b1, 4'hF, 3'd1, 8'b1011_0000},
            {1'b1, 1'b1, 4'hF, 3'd2, 8'b0000_0000},
            {1'b1, 1'b1, 4'h0, 3'd6, 8'b0000_0010},
            {1'b0, 1'b0, 4'h0, 3'd6, 8'b0000_0010},
            {1'b1, 1'b1, 4'h3, 3'd6, 8'b0000_0010}
        };
        for (int i = 0; i < 11; i++) begin
            if (i == 5) pulse_reset();
            run = v[i].r; memAck = v[i].a; opcode = v[i].op;
            #1;
            n_checks++;
            if (obs !== {v[i].st, v[i].b}) begin
                n_fail++;
                $display("FAIL illegal_halt[%0d]: got %h expected %h", i, obs, {v[i].st, v[i].b});
            end
            @(negedge clk);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_fetch;
        run = 1'b1; memAck = 1'b0; opcode = 4'h0;
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== {3'd1, 8'b1000_0000}) begin
            n_fail++;
            $display("FAIL midreset_fetch: got %h expected %h", obs, {3'd1, 8'b1000_0000});
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL midreset_async: got %h expected %h", obs, 11'h000);
        end
        @(negedge clk);
        reset = 1'b1; run = 1'b0; memAck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (obs !== 11'h000) begin
                n_fail++;
                $display("FAIL midreset_late_ack[%0d]: got %h expected %h", i, obs, 11'h000);
            end
            @(negedge clk);
        end
        memAck = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; memAck = 1'b0; opcode = 4'h0;
        test_reset();
        test_alu();
        test_jump();
        test_load();
        test_store_run_drop();
        test_timeout();
        test_illegal_and_halt();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
